// File: rtl/count_connected_stream_driver_if.sv
// Bot stream, core handshake and per-top report signals of the
// connected-count stream driver, bundled into one interface.
interface count_connected_stream_driver_if #(
    parameter int SUM_WIDTH   = 64,
    parameter int COUNT_WIDTH = 32
);
    // upstream bot stream
    logic                   botInValid;
    logic [127:0]           botIn;
    logic                   botInLast;
    logic                   botInReady;
    // towards the core
    logic                   isBotValid;
    logic [127:0]           graphIn;
    logic                   extraDataIn;
    logic                   slowDownInput;
    // back from the core
    logic                   resultValid;
    logic [5:0]             connectCount;
    logic                   extraDataOut;
    logic                   eccStatus;
    // per-top report
    logic                   resultSumValid;
    logic [SUM_WIDTH-1:0]   resultSum;
    logic [COUNT_WIDTH-1:0] resultBotCount;
    logic                   resultErr;
    logic                   busy;

    // driver side
    modport master (
        input  botInValid, botIn, botInLast, slowDownInput,
               resultValid, connectCount, extraDataOut, eccStatus,
        output botInReady, isBotValid, graphIn, extraDataIn,
               resultSumValid, resultSum, resultBotCount, resultErr, busy
    );

    // bot source / core / report consumer side
    modport slave (
        output botInValid, botIn, botInLast, slowDownInput,
               resultValid, connectCount, extraDataOut, eccStatus,
        input  botInReady, isBotValid, graphIn, extraDataIn,
               resultSumValid, resultSum, resultBotCount, resultErr, busy
    );
endinterface

// File: rtl/count_connected_stream_driver.sv
// Feeds bots into the connected-count core, tags each with its top's last
// flag, and accumulates sum(2^connectCount) per top until the last result
// comes back, then reports sum, bot count and a sticky error flag.
module count_connected_stream_driver #(
    parameter int SUM_WIDTH     = 64,
    parameter int COUNT_WIDTH   = 32,
    parameter int MAX_IN_FLIGHT = 512
) (
    input  logic clk,
    input  logic rst,
    count_connected_stream_driver_if.master bus
);

    localparam int OUT_W = $clog2(MAX_IN_FLIGHT) + 1;
    localparam logic [OUT_W:0] MAX_LIMIT = (OUT_W+1)'(MAX_IN_FLIGHT);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, REPORT} state_t;

    state_t                 state_reg, state_next;
    logic [OUT_W-1:0]       outstanding_reg;
    logic [SUM_WIDTH-1:0]   sum_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   err_reg;

    logic                   issue_valid_reg;
    logic [127:0]           graph_reg;
    logic                   extra_reg;

    logic                   report_valid_reg;
    logic [SUM_WIDTH-1:0]   report_sum_reg;
    logic [COUNT_WIDTH-1:0] report_count_reg;
    logic                   report_err_reg;

    logic                   accepting;
    logic                   busy_int;
    logic [OUT_W:0]         in_flight;
    logic                   bot_ready;
    logic                   transfer;
    logic                   last_result;

    logic                   cc_too_big;
    logic [SUM_WIDTH-1:0]   term;
    logic [SUM_WIDTH-1:0]   sum_added;
    logic                   sum_carry;
    logic [SUM_WIDTH-1:0]   sum_next;
    logic                   count_sat;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   err_event;

    assign transfer    = bus.botInValid && bot_ready;
    assign last_result = bus.resultValid && bus.extraDataOut;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (transfer) state_next = bus.botInLast ? DRAIN : STREAM;
            STREAM: if (transfer && bus.botInLast) state_next = DRAIN;
            DRAIN:  if (last_result) state_next = REPORT;
            REPORT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs: upstream ready and busy.
    // The bot sitting in the issue register is counted as in flight so that
    // back-to-back transfers can never push the core past its ring depth.
    always_comb begin
        accepting = (state_reg == IDLE) || (state_reg == STREAM);
        busy_int  = (state_reg != IDLE);
        in_flight = {1'b0, outstanding_reg} + (OUT_W+1)'(issue_valid_reg);
        bot_ready = !rst && accepting && !bus.slowDownInput && (in_flight < MAX_LIMIT);
    end

    // Accumulator term, bot counter and per-cycle error events
    always_comb begin
        cc_too_big = ({26'd0, bus.connectCount} >= 32'(SUM_WIDTH));
        term       = cc_too_big ? '0
                                : ({{(SUM_WIDTH-1){1'b0}}, 1'b1} << bus.connectCount);
        {sum_carry, sum_added} = {1'b0, sum_reg} + {1'b0, term};
        sum_next   = bus.resultValid ? sum_added : sum_reg;
        count_sat  = &count_reg;
        count_next = (transfer && !count_sat) ? count_reg + 1'b1 : count_reg;
        err_event  = bus.eccStatus
                   || (bus.resultValid && (outstanding_reg == '0))
                   || (bus.resultValid && ((state_reg == IDLE) || (state_reg == REPORT)))
                   || (bus.resultValid && (cc_too_big || sum_carry))
                   || (last_result && (outstanding_reg != OUT_W'(1)))
                   || (transfer && count_sat);
    end

    // Issue register, outstanding tracking, per-top accumulation and report
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_reg  <= 1'b0;
            graph_reg        <= '0;
            extra_reg        <= 1'b0;
            outstanding_reg  <= '0;
            sum_reg          <= '0;
            count_reg        <= '0;
            err_reg          <= 1'b0;
            report_valid_reg <= 1'b0;
            report_sum_reg   <= '0;
            report_count_reg <= '0;
            report_err_reg   <= 1'b0;
        end else begin
            issue_valid_reg <= transfer;
            if (transfer) begin
                graph_reg <= bus.botIn;
                extra_reg <= bus.botInLast;
            end

            // An unmatched result with nothing outstanding is flagged, not counted.
            if (issue_valid_reg && !bus.resultValid)
                outstanding_reg <= outstanding_reg + 1'b1;
            else if (!issue_valid_reg && bus.resultValid && (outstanding_reg != '0))
                outstanding_reg <= outstanding_reg - 1'b1;

            // Events seen during REPORT belong to the next top.
            if (state_reg == REPORT) begin
                sum_reg   <= '0;
                count_reg <= '0;
                err_reg   <= err_event;
            end else begin
                sum_reg   <= sum_next;
                count_reg <= count_next;
                err_reg   <= err_reg || err_event;
            end

            report_valid_reg <= (state_reg == DRAIN) && last_result;
            if ((state_reg == DRAIN) && last_result) begin
                report_sum_reg   <= sum_next;
                report_count_reg <= count_next;
                report_err_reg   <= err_reg || err_event;
            end
        end
    end

    assign bus.botInReady     = bot_ready;
    assign bus.isBotValid     = issue_valid_reg;
    assign bus.graphIn        = graph_reg;
    assign bus.extraDataIn    = extra_reg;
    assign bus.resultSumValid = report_valid_reg;
    assign bus.resultSum      = report_sum_reg;
    assign bus.resultBotCount = report_count_reg;
    assign bus.resultErr      = report_err_reg;
    assign bus.busy           = busy_int;

endmodule

// File: tb/tb_count_connected_stream_driver.sv
// Directed bench for count_connected_stream_driver: the bench plays bot
// source and core; issued bots and reports are checked by monitors against
// scoreboard queues filled when stimulus is applied.
module tb_count_connected_stream_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_connected_stream_driver_if #(.SUM_WIDTH(64), .COUNT_WIDTH(32)) bus ();

    count_connected_stream_driver #(
        .SUM_WIDTH(64), .COUNT_WIDTH(32), .MAX_IN_FLIGHT(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [63:0] sum;
        logic [31:0] cnt;
        logic        err;
    } rep_t;

    logic [128:0] iss_q[$];
    rep_t         rep_q[$];
    int tests = 0;
    int fails = 0;
    int gap_issues;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue monitor: every isBotValid must match the oldest accepted bot.
    always @(negedge clk) begin
        if (!rst && bus.isBotValid) begin
            if (iss_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL issue_unexpected: graph %0h with no bot pending", bus.graphIn);
            end else begin
                logic [128:0] e;
                e = iss_q.pop_front();
                chk("issue_graph", bus.graphIn, e[127:0]);
                chk("issue_last", 128'(bus.extraDataIn), 128'(e[128]));
                $display("[TB] issue graph=%0h last=%0b", bus.graphIn, bus.extraDataIn);
            end
        end
    end

    // Report monitor
    always @(negedge clk) begin
        if (!rst && bus.resultSumValid) begin
            if (rep_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL report_unexpected: sum %0h with no report pending", bus.resultSum);
            end else begin
                rep_t r;
                r = rep_q.pop_front();
                chk("report_sum", 128'(bus.resultSum), 128'(r.sum));
                chk("report_count", 128'(bus.resultBotCount), 128'(r.cnt));
                chk("report_err", 128'(bus.resultErr), 128'(r.err));
                $display("[TB] report sum=%0h count=%0d err=%0b",
                         bus.resultSum, bus.resultBotCount, bus.resultErr);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic send_bot(input logic [127:0] g, input logic last);
        logic done;
        done = 1'b0;
        bus.botInValid = 1'b1;
        bus.botIn      = g;
        bus.botInLast  = last;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (bus.botInReady) begin
                iss_q.push_back({last, g});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.botInValid = 1'b0;
        bus.botInLast  = 1'b0;
        if (!done) chk("send_timeout", 128'(done), 128'(1));
    endtask

    task automatic ret(input logic [5:0] cc, input logic last);
        bus.resultValid  = 1'b1;
        bus.connectCount = cc;
        bus.extraDataOut = last;
        @(posedge clk); #1;
        bus.resultValid  = 1'b0;
        bus.extraDataOut = 1'b0;
    endtask

    // Called right after the last result: REPORT now, IDLE the cycle after.
    task automatic finish_top();
        @(negedge clk);
        chk("report_pulse", 128'(bus.resultSumValid), 128'(1));
        chk("busy_in_report", 128'(bus.busy), 128'(1));
        chk("ready_in_report", 128'(bus.botInReady), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_report", 128'(bus.busy), 128'(0));
        chk("ready_after_report", 128'(bus.botInReady), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.botInValid = 0; bus.botIn = '0; bus.botInLast = 0;
        bus.slowDownInput = 0; bus.resultValid = 0; bus.connectCount = '0;
        bus.extraDataOut = 0; bus.eccStatus = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 128'(bus.botInReady), 128'(0));
        chk("rst_isbot", 128'(bus.isBotValid), 128'(0));
        chk("rst_pulse", 128'(bus.resultSumValid), 128'(0));
        chk("rst_sum", 128'(bus.resultSum), 128'(0));
        chk("rst_count", 128'(bus.resultBotCount), 128'(0));
        chk("rst_err", 128'(bus.resultErr), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_graph", bus.graphIn, 128'(0));
        chk("rst_extra", 128'(bus.extraDataIn), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single top: counts 0,1,5 -> 1+2+32 = 35
        rep_q.push_back('{sum: 64'd35, cnt: 32'd3, err: 1'b0});
        send_bot(128'h11, 0);
        send_bot(128'h22, 0);
        send_bot(128'h33, 1);
        repeat (520) @(posedge clk);
        #1;
        ret(6'd0, 0);
        ret(6'd1, 0);
        ret(6'd5, 1);
        finish_top();

        // Backpressure: slowDownInput high cycles 10..20 under continuous valid
        rep_q.push_back('{sum: 64'd200, cnt: 32'd200, err: 1'b0});
        gap_issues = 0;
        fork
            begin
                int k;
                k = 0;
                for (int cyc = 0; cyc < 1000 && k < 200; cyc++) begin
                    logic took;
                    bus.botInValid = 1'b1;
                    bus.botIn      = 128'(k) + 128'h1000;
                    bus.botInLast  = (k == 199);
                    @(negedge clk);
                    took = bus.botInReady;
                    if (took) iss_q.push_back({(k == 199), 128'(k) + 128'h1000});
                    @(posedge clk); #1;
                    if (took) k++;
                end
                bus.botInValid = 1'b0;
                bus.botInLast  = 1'b0;
                chk("bp_all_sent", 128'(k), 128'(200));
            end
            begin
                repeat (10) begin @(posedge clk); #1; end
                bus.slowDownInput = 1'b1;
                for (int i = 0; i <= 10; i++) begin
                    @(posedge clk); #1;
                    if (i == 10) bus.slowDownInput = 1'b0;
                    @(negedge clk);
                    if (bus.isBotValid) gap_issues++;
                end
                chk("bp_no_issue_window", 128'(gap_issues), 128'(0));
            end
        join
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) ret(6'd0, (i == 199));
        finish_top();

        // Single-bot top straight from IDLE, count 63 -> 2^63
        rep_q.push_back('{sum: 64'h8000_0000_0000_0000, cnt: 32'd1, err: 1'b0});
        send_bot(128'hABC, 1);
        @(negedge clk);
        chk("single_busy", 128'(bus.busy), 128'(1));
        chk("single_ready_drain", 128'(bus.botInReady), 128'(0));
        @(posedge clk); #1;
        ret(6'd63, 1);
        finish_top();

        // Spurious result in IDLE: 4 + 8 = 12, error set
        rep_q.push_back('{sum: 64'd12, cnt: 32'd1, err: 1'b1});
        ret(6'd2, 0);
        send_bot(128'h5A, 1);
        ret(6'd3, 1);
        finish_top();

        // ECC pulse mid-top: 2 + 4 = 6, error set
        rep_q.push_back('{sum: 64'd6, cnt: 32'd2, err: 1'b1});
        send_bot(128'h61, 0);
        bus.eccStatus = 1'b1;
        @(posedge clk); #1;
        bus.eccStatus = 1'b0;
        send_bot(128'h62, 1);
        ret(6'd1, 0);
        ret(6'd2, 1);
        finish_top();

        // Last flag returned with 2 outstanding: 16, error set
        rep_q.push_back('{sum: 64'd16, cnt: 32'd2, err: 1'b1});
        send_bot(128'h71, 0);
        send_bot(128'h72, 1);
        repeat (2) @(posedge clk);
        #1;
        ret(6'd4, 1);
        finish_top();
        pulse_reset();

        // Outstanding limit: 512 issued, none returned
        for (int i = 0; i < 512; i++) send_bot(128'(i) + 128'h2000, 0);
        @(negedge clk);
        chk("ready_at_limit", 128'(bus.botInReady), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_at_512", 128'(bus.botInReady), 128'(0));
        @(posedge clk); #1;
        ret(6'd0, 0);
        @(negedge clk);
        chk("ready_at_511", 128'(bus.botInReady), 128'(1));
        // Issue and result in the same cycle: outstanding stays at 511
        bus.botInValid = 1'b1;
        bus.botIn      = 128'h3000;
        bus.botInLast  = 1'b0;
        iss_q.push_back({1'b0, 128'h3000});
        @(posedge clk); #1;
        bus.botInValid   = 1'b0;
        bus.resultValid  = 1'b1;
        bus.connectCount = 6'd0;
        @(posedge clk); #1;
        bus.resultValid  = 1'b0;
        @(negedge clk);
        chk("ready_after_simul", 128'(bus.botInReady), 128'(1));
        @(posedge clk); #1;
        send_bot(128'h3001, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_full_again", 128'(bus.botInReady), 128'(0));
        @(posedge clk); #1;
        pulse_reset();

        // Reset mid-DRAIN, then a clean 2-bot top
        send_bot(128'h81, 0);
        send_bot(128'h82, 1);
        ret(6'd5, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_isbot", 128'(bus.isBotValid), 128'(0));
        chk("mid_rst_pulse", 128'(bus.resultSumValid), 128'(0));
        chk("mid_rst_sum", 128'(bus.resultSum), 128'(0));
        chk("mid_rst_count", 128'(bus.resultBotCount), 128'(0));
        chk("mid_rst_err", 128'(bus.resultErr), 128'(0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_graph", bus.graphIn, 128'(0));
        chk("mid_rst_extra", 128'(bus.extraDataIn), 128'(0));
        @(posedge clk); #1;
        rep_q.push_back('{sum: 64'd12, cnt: 32'd2, err: 1'b0});
        send_bot(128'h91, 0);
        send_bot(128'h92, 1);
        ret(6'd2, 0);
        ret(6'd3, 1);
        finish_top();

        repeat (5) @(posedge clk);
        #1;
        chk("issue_queue_empty", 128'(iss_q.size()), 128'(0));
        chk("report_queue_empty", 128'(rep_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
